// File: rtl/flip_pkg.sv
// Shared definitions for the bit-flipping path: default sizes, the word+flag
// record and a width-generic bit reversal usable by sender, receiver and checkers.
package flip_pkg;

   localparam int FLIP_N_DEF     = 16;
   localparam int FLIP_DEPTH_DEF = 4;
   // Widest word bit_reverse can handle; callers pass their own width in n.
   localparam int FLIP_MAX_N     = 64;

   typedef struct packed {
      logic                  f;
      logic [FLIP_N_DEF-1:0] data;
   } flip_word_t;

   // Reverses the low n bits of v (n <= FLIP_MAX_N); upper result bits are zero.
   // The full-width reversal moves bit n-1 to position MAX_N-n, so one right
   // shift realigns the n-bit field to bit 0.
   function automatic logic [FLIP_MAX_N-1:0] bit_reverse(input logic [FLIP_MAX_N-1:0] v,
                                                         input int unsigned           n);
      logic [FLIP_MAX_N-1:0] r;
      for (int i = 0; i < FLIP_MAX_N; i++) begin
         r[i] = v[FLIP_MAX_N-1-i];
      end
      return r >> (FLIP_MAX_N - n);
   endfunction

endpackage

// File: rtl/fifo_flip_sinc.sv
// DEPTH x W synchronous FIFO with occupancy counter; full/empty come straight
// from the registered count so they never depend on same-cycle push/pop.
module fifo_flip_sinc #(
   parameter int W     = 17,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CNW = AW + 1;

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CNW-1:0]          count_q, count_d;
   logic                    push_ok, pop_ok;

   assign full    = (count_q == CNW'(DEPTH));
   assign empty   = (count_q == '0);
   // Guard locally so a misbehaving neighbour cannot overflow or underflow.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Next-state for storage, pointers (power-of-2 wrap) and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNW'(1);
         2'b01:   count_d = count_q - CNW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers; reset empties the queue without touching storage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/mecanismo_desflipping_flujo.sv
// Receiving end of the bit-flipping path: buffers {f, word} pairs, restores the
// original bit order at the FIFO head and keeps saturating word statistics.
module mecanismo_desflipping_flujo
   import flip_pkg::*;
#(
   parameter int N     = FLIP_N_DEF,    // must not exceed FLIP_MAX_N
   parameter int DEPTH = FLIP_DEPTH_DEF,
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_stats,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_f,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic          out_f,
   output logic [CW-1:0] cnt_total,
   output logic [CW-1:0] cnt_flipped
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic          fifo_full, fifo_empty;
   logic          push, pop;
   logic [N:0]    head;
   logic          head_f;
   logic [N-1:0]  head_data;
   logic [N-1:0]  head_rev;
   logic [CW-1:0] cnt_total_q, cnt_total_d;
   logic [CW-1:0] cnt_flipped_q, cnt_flipped_d;

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   fifo_flip_sinc #(
      .W     (N + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({in_f, in_data}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_f    = head[N];
   assign head_data = head[N-1:0];
   assign head_rev  = N'(bit_reverse(FLIP_MAX_N'(head_data), N));

   // Un-flip at the head; outputs are forced to zero while nothing is buffered.
   always_comb begin
      out_data = '0;
      out_f    = 1'b0;
      if (!fifo_empty) begin
         out_f    = head_f;
         out_data = head_f ? head_rev : head_data;
      end
   end

   // Statistics: clear wins over an increment; both counters stick at all-ones.
   always_comb begin
      cnt_total_d   = cnt_total_q;
      cnt_flipped_d = cnt_flipped_q;
      if (clr_stats) begin
         cnt_total_d   = '0;
         cnt_flipped_d = '0;
      end else if (push) begin
         if (cnt_total_q != CNT_MAX) cnt_total_d = cnt_total_q + CW'(1);
         if (in_f && (cnt_flipped_q != CNT_MAX)) cnt_flipped_d = cnt_flipped_q + CW'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_total_q   <= '0;
         cnt_flipped_q <= '0;
      end else begin
         cnt_total_q   <= cnt_total_d;
         cnt_flipped_q <= cnt_flipped_d;
      end
   end

   assign cnt_total   = cnt_total_q;
   assign cnt_flipped = cnt_flipped_q;

endmodule
